// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if
//   Control and status bundle between the key/switch logic and the tone
//   sequencer. The master drives the requests and sees the note/gate outputs.
//   The slave is the sequencer itself.
//
//   start         level, begins a sequence when the sequencer is idle
//   stop          level, aborts any sequence (wins over start)
//   mode          00 ascending, 01 descending, 10 ping-pong, 11 ascending
//   loop          1 = restart after the last note instead of finishing
//   frequency_sel note select for the clock divider
//   tone_en       high while a note sounds
//   busy          high during PLAY and GAP
//   beat_pulse    one-cycle pulse on the last cycle of each note
//   done          one-cycle pulse when a non-looping sequence completes
interface tone_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       loop;
    logic [2:0] frequency_sel;
    logic       tone_en;
    logic       busy;
    logic       beat_pulse;
    logic       done;

    modport master (
        output start, stop, mode, loop,
        input  frequency_sel, tone_en, busy, beat_pulse, done
    );

    modport slave (
        input  start, stop, mode, loop,
        output frequency_sel, tone_en, busy, beat_pulse, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Steps the clock divider's 3-bit frequency_sel through an ascending,
//   descending or ping-pong note sequence. Each note sounds for
//   TICKS_PER_BEAT cycles (tone_en high), followed by GAP_TICKS silent
//   cycles. The sequence either runs once (done pulse) or loops.
//
//   CLOCK_50  system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       tone_sequencer_if.slave: start/stop/mode/loop in,
//             frequency_sel/tone_en/busy/beat_pulse/done out (all registered)
module tone_sequencer #(
    parameter int TICKS_PER_BEAT = 25000000,
    parameter int GAP_TICKS      = 2500000,
    parameter int CNT_W          = 25
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    tone_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] BEAT_LAST     = CNT_W'(TICKS_PER_BEAT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit               ONE_TICK_BEAT = (TICKS_PER_BEAT == 1);

    state_t           state_reg;
    logic [CNT_W-1:0] tick_reg;
    logic [2:0]       note_reg;
    logic             dir_down_reg;   // ping-pong leg: 0 = up, 1 = down
    logic [1:0]       mode_reg;       // latched at start, 11 folded to 00
    logic             loop_reg;
    logic             tone_en_reg;
    logic             busy_reg;
    logic             beat_pulse_reg;
    logic             done_reg;

    // Next note, end-of-sequence detection and the moment a note (including
    // its gap) is finished.
    logic       seq_last;
    logic [2:0] note_next;
    logic       dir_down_next;
    logic       advance;

    always_comb begin
        seq_last      = 1'b0;
        note_next     = note_reg + 3'd1;
        dir_down_next = dir_down_reg;
        case (mode_reg)
            2'b01: begin
                seq_last  = (note_reg == 3'd0);
                note_next = note_reg - 3'd1;
            end
            2'b10: begin
                if (dir_down_reg) begin
                    seq_last  = (note_reg == 3'd0);
                    note_next = note_reg - 3'd1;
                end else if (note_reg == 3'd7) begin
                    // top of the up leg: turn around without repeating 7
                    dir_down_next = 1'b1;
                    note_next     = 3'd6;
                end
            end
            default: seq_last = (note_reg == 3'd7);
        endcase

        // With no gap the note ends on the terminal PLAY tick, otherwise on
        // the terminal GAP tick.
        advance = ((state_reg == PLAY) && (tick_reg == BEAT_LAST) && (GAP_TICKS == 0)) ||
                  ((state_reg == GAP)  && (tick_reg == GAP_LAST));
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            tick_reg       <= '0;
            note_reg       <= 3'd0;
            dir_down_reg   <= 1'b0;
            mode_reg       <= 2'b00;
            loop_reg       <= 1'b0;
            tone_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            beat_pulse_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            beat_pulse_reg <= 1'b0;
            done_reg       <= 1'b0;

            if (bus.stop) begin
                state_reg    <= IDLE;
                tick_reg     <= '0;
                note_reg     <= 3'd0;
                dir_down_reg <= 1'b0;
                tone_en_reg  <= 1'b0;
                busy_reg     <= 1'b0;
            end else if (advance) begin
                if (seq_last && !loop_reg) begin
                    state_reg    <= DONE;
                    tick_reg     <= '0;
                    note_reg     <= 3'd0;
                    dir_down_reg <= 1'b0;
                    tone_en_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0 | 1'b1;
                end else begin
                    state_reg      <= PLAY;
                    tick_reg       <= '0;
                    tone_en_reg    <= 1'b1;
                    busy_reg       <= 1'b1;
                    beat_pulse_reg <= ONE_TICK_BEAT;
                    if (seq_last) begin
                        // looping: reload the first note, ping-pong restarts upward
                        note_reg     <= (mode_reg == 2'b01) ? 3'd7 : 3'd0;
                        dir_down_reg <= 1'b0;
                    end else begin
                        note_reg     <= note_next;
                        dir_down_reg <= dir_down_next;
                    end
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            mode_reg       <= (bus.mode == 2'b11) ? 2'b00 : bus.mode;
                            loop_reg       <= bus.loop;
                            dir_down_reg   <= 1'b0;
                            note_reg       <= (bus.mode == 2'b01) ? 3'd7 : 3'd0;
                            tick_reg       <= '0;
                            state_reg      <= PLAY;
                            tone_en_reg    <= 1'b1;
                            busy_reg       <= 1'b1;
                            beat_pulse_reg <= ONE_TICK_BEAT;
                        end
                    end
                    PLAY: begin
                        if (tick_reg == BEAT_LAST) begin
                            // only reached with a non-zero gap; the no-gap
                            // case is handled by advance
                            state_reg   <= GAP;
                            tick_reg    <= '0;
                            tone_en_reg <= 1'b0;
                        end else begin
                            tick_reg <= tick_reg + CNT_W'(1);
                            // registered pulse must be high during the
                            // terminal tick, so raise it one cycle early
                            beat_pulse_reg <= ((tick_reg + CNT_W'(1)) == BEAT_LAST);
                        end
                    end
                    GAP: begin
                        tick_reg <= tick_reg + CNT_W'(1);
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.frequency_sel = note_reg;
    assign bus.tone_en       = tone_en_reg;
    assign bus.busy          = busy_reg;
    assign bus.beat_pulse    = beat_pulse_reg;
    assign bus.done          = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer
//   Two sequencers (GAP_TICKS=1 and GAP_TICKS=0, TICKS_PER_BEAT=4) share the
//   same stimulus. For every accepted start the bench expands the note list
//   of the chosen mode into a per-cycle plan of expected outputs; each cycle
//   the next planned value is queued and a separate monitor compares it with
//   the outputs on the falling edge.
module tb_tone_sequencer;
    localparam int T = 4;

    typedef struct packed {
        logic [2:0] freq;
        logic       ten;
        logic       busy;
        logic       beat;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start, stop, loop;
    logic [1:0] mode;

    always #5 clk = ~clk;

    tone_sequencer_if bus0();
    tone_sequencer_if bus1();

    assign bus0.start = start;
    assign bus0.stop  = stop;
    assign bus0.mode  = mode;
    assign bus0.loop  = loop;
    assign bus1.start = start;
    assign bus1.stop  = stop;
    assign bus1.mode  = mode;
    assign bus1.loop  = loop;

    tone_sequencer #(.TICKS_PER_BEAT(T), .GAP_TICKS(1), .CNT_W(4)) dut_g1 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus0.slave)
    );

    tone_sequencer #(.TICKS_PER_BEAT(T), .GAP_TICKS(0), .CNT_W(4)) dut_g0 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus1.slave)
    );

    exp_t act [2];
    assign act[0] = {bus0.frequency_sel, bus0.tone_en, bus0.busy, bus0.beat_pulse, bus0.done};
    assign act[1] = {bus1.frequency_sel, bus1.tone_en, bus1.busy, bus1.beat_pulse, bus1.done};

    exp_t       exp_q  [2][$];   // expected outputs, one entry per cycle
    exp_t       plan_q [2][$];   // remaining planned cycles of the running sequence
    exp_t       last_exp [2];    // expected outputs of the current cycle
    bit         looping [2];
    logic [1:0] lat_mode [2];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    function automatic int gap_of(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // One pass through the note list: T sounding cycles then the gap per note.
    function automatic void append_iteration(int i, logic [1:0] m);
        int   notes[$];
        exp_t e;
        if (m == 2'b01) begin
            for (int n = 7; n >= 0; n--) notes.push_back(n);
        end else if (m == 2'b10) begin
            for (int n = 0; n <= 7; n++) notes.push_back(n);
            for (int n = 6; n >= 0; n--) notes.push_back(n);
        end else begin
            for (int n = 0; n <= 7; n++) notes.push_back(n);
        end
        foreach (notes[k]) begin
            for (int t = 0; t < T; t++) begin
                e.freq = 3'(notes[k]); e.ten = 1'b1; e.busy = 1'b1;
                e.beat = (t == T - 1); e.done = 1'b0;
                plan_q[i].push_back(e);
            end
            for (int g = 0; g < gap_of(i); g++) begin
                e.freq = 3'(notes[k]); e.ten = 1'b0; e.busy = 1'b1;
                e.beat = 1'b0; e.done = 1'b0;
                plan_q[i].push_back(e);
            end
        end
    endfunction

    // Apply inputs for the next edge, queue the expected outputs of the next
    // cycle, then advance one clock (returns #1 after the edge).
    task automatic drive(input logic s, input logic p, input logic [1:0] m, input logic l);
        exp_t nxt;
        start = s; stop = p; mode = m; loop = l;
        for (int i = 0; i < 2; i++) begin
            nxt = '0;
            if (p) begin
                plan_q[i].delete();
                looping[i] = 1'b0;
            end else begin
                if (s && last_exp[i] == '0) begin
                    lat_mode[i] = m;
                    looping[i]  = l;
                    append_iteration(i, m);
                    if (!l) plan_q[i].push_back(exp_t'(7'b000_0001));
                end
                if (plan_q[i].size() == 0 && looping[i]) append_iteration(i, lat_mode[i]);
                if (plan_q[i].size() > 0) nxt = plan_q[i].pop_front();
            end
            exp_q[i].push_back(nxt);
            last_exp[i] = nxt;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== '0) begin
                errors++;
                $display("FAIL %s dut%0d (gap=%0d) cyc %0d: got outputs %b, want 0000000",
                         name, i, gap_of(i), cyc, act[i]);
            end
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            exp_q[i].push_back('0);
            plan_q[i].delete();
            looping[i]  = 1'b0;
            last_exp[i] = '0;
        end
    endtask

    // Monitor: pop and compare once per cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() > 0) begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    checks++;
                    if (act[i] !== e) begin
                        errors++;
                        $display("FAIL outputs dut%0d (gap=%0d) cyc %0d: got freq=%0d ten=%0b busy=%0b beat=%0b done=%0b, want freq=%0d ten=%0b busy=%0b beat=%0b done=%0b",
                                 i, gap_of(i), cyc, act[i].freq, act[i].ten, act[i].busy, act[i].beat, act[i].done,
                                 e.freq, e.ten, e.busy, e.beat, e.done);
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        start = 1'b0; stop = 1'b0; mode = 2'b00; loop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_exp[i] = '0;
            looping[i]  = 1'b0;
            lat_mode[i] = 2'b00;
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        reset_model();

        // single runs of each mode
        drive(1, 0, 2'b00, 0); repeat (45) drive(0, 0, 2'b00, 0);
        drive(1, 0, 2'b01, 0); repeat (45) drive(0, 0, 2'b00, 0);
        drive(1, 0, 2'b10, 0); repeat (80) drive(0, 0, 2'b00, 0);
        drive(1, 0, 2'b11, 0); repeat (45) drive(0, 0, 2'b00, 0);

        // looping ascending, mode/loop changes while busy, then stop
        drive(1, 0, 2'b00, 1); repeat (90) drive(0, 0, 2'b10, 0);
        drive(0, 1, 2'b00, 0); repeat (3) drive(0, 0, 2'b00, 0);

        // start while busy ignored; stop+start together; then a fresh start
        drive(1, 0, 2'b10, 0); repeat (10) drive(1, 0, 2'b01, 1);
        drive(1, 1, 2'b00, 0);
        drive(1, 0, 2'b00, 0); repeat (45) drive(0, 0, 2'b00, 0);

        // start held high: back-to-back sequences separated by DONE + IDLE
        repeat (100) drive(1, 0, 2'b01, 0);
        drive(0, 1, 2'b00, 0); repeat (2) drive(0, 0, 2'b00, 0);

        // asynchronous reset in the middle of a gap
        drive(1, 0, 2'b00, 0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                if (last_exp[0].busy && !last_exp[0].ten) found = 1'b1;
                else drive(0, 0, 2'b00, 0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL gap_search cyc %0d: got no gap within 20 cycles, want a gap", cyc);
        end
        #1 reset_n = 1'b0;
        #1 check_zero("async_reset");
        reset_model();
        repeat (2) drive(0, 0, 2'b00, 0);
        reset_n = 1'b1;
        repeat (6) drive(0, 0, 2'b00, 0);

        // randomized traffic
        repeat (4000) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        drive(0, 1, 2'b00, 0);
        drive(0, 0, 2'b00, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
